// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, streams word reads from mem into a small
// PC-tagged prefetch FIFO, and hands instructions to decode over valid/ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        nrst,
  output logic [31:0] mem_addr,
  output logic        mem_wr_en,
  input  logic [31:0] mem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [31:0]      pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [31:0]      inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      tag_q  [DEPTH];
  logic [31:0]      tag_d  [DEPTH];

  logic             pop, push, issue;
  logic [OCC_W-1:0] occ;
  logic [CNT_W-1:0] wr_idx;

  assign inst_valid = (count_q != '0);
  assign pop        = inst_valid & inst_ready;
  assign push       = inflight_q & ~redirect;

  // Credit check: words held plus the one returning, minus the one leaving.
  assign occ    = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign issue  = ~redirect & (occ < OCC_W'(DEPTH));
  assign wr_idx = pop ? (count_q - CNT_W'(1)) : count_q;

  assign mem_addr  = pc_q;
  assign mem_wr_en = 1'b0;
  assign inst      = inst_valid ? data_q[0] : 32'h0;
  assign inst_pc   = inst_valid ? tag_q[0]  : 32'h0;

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    if (redirect) begin
      pc_d = redirect_pc & 32'hFFFF_FFFC;
    end else if (issue) begin
      pc_d          = pc_q + 32'd4;
      inflight_pc_d = pc_q;
    end
  end

  // Shift-register FIFO: entry 0 is always the head, vacated slots are zeroed.
  always_comb begin
    data_d  = data_q;
    tag_d   = tag_q;
    count_d = count_q;
    if (redirect) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_d[i] = 32'h0;
        tag_d[i]  = 32'h0;
      end
      count_d = '0;
    end else begin
      if (pop) begin
        for (int unsigned i = 0; i < DEPTH - 1; i++) begin
          data_d[i] = data_q[i+1];
          tag_d[i]  = tag_q[i+1];
        end
        data_d[DEPTH-1] = 32'h0;
        tag_d[DEPTH-1]  = 32'h0;
      end
      if (push) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            data_d[i] = mem_data;
            tag_d[i]  = inflight_pc_q;
          end
        end
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 32'h0;
      count_q       <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= 32'h0;
        tag_q[i]  <= 32'h0;
      end
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= data_d[i];
        tag_q[i]  <= tag_d[i];
      end
    end
  end

endmodule
